aes_enc_round_engine: RTL and testbench
=======================================

// Module: aes_enc_round_engine
// PURPOSE
//   Iterative AES cipher (encrypt direction): SubBytes -> ShiftRows -> MixColumns -> AddRoundKey,
//   one round per clock. Forward counterpart of the receiver's inverse-cipher datapath.
//   Sits in the transmitter between the plaintext source and the SHA/packet stage.
//   Round keys come from an external key-schedule block through an indexed lookup.
// PARAMETERS
//   NR   14   number of rounds (10/12/14 for AES-128/192/256); round counter width = 4 bits
// PORTS
//   clk        in   1    system clock, all state on rising edge
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    plaintext block valid
//   in_ready   out  1    engine idle, block accepted when in_valid & in_ready
//   in_data    in   128  plaintext, [0:127], byte i = in_data[8*i+:8]
//   rk_idx     out  4    round-key index requested this cycle (0..NR)
//   rk         in   128  round key for rk_idx, same-cycle combinational return, same byte order
//   out_valid  out  1    ciphertext valid, held until out_ready
//   out_ready  in   1    downstream accepts ciphertext
//   out_data   out  128  ciphertext, same byte order
//   busy       out  1    high in ROUND or DONE
// BEHAVIOUR
//   State layout: column-major, state(r,c) = byte 4*c+r (row r, column c).
//   ShiftRows: new(r,c) = old(r,(c+r) mod 4) -- row r rotated left by r.
//   MixColumns: per column, matrix {02 03 01 01 / 01 02 03 01 / 01 01 02 03 / 03 01 01 02}
//     over GF(2^8), reduction polynomial 0x11B (xtime: shift left, XOR 0x1B on carry-out).
//   SubBytes: forward FIPS-197 S-box, 16 parallel instances, purely combinational.
//   Reset (async, rst_n=0): FSM=IDLE, round counter=0, state reg=0, in_ready=1, out_valid=0,
//     out_data=0, busy=0, rk_idx=0. Registers clear immediately, independent of clk.
//   FSM states:
//     IDLE : in_ready=1, rk_idx=0. On in_valid: state <= in_data ^ rk, ctr <= 1, go ROUND.
//     ROUND: in_ready=0, rk_idx=ctr. Each cycle state <= AddRoundKey(rk) of the round result.
//            ctr<NR : full round (incl. MixColumns), ctr <= ctr+1.
//            ctr==NR: final round, MixColumns bypassed; result -> out_data, go DONE.
//     DONE : out_valid=1, out_data stable, rk_idx=0. On out_ready: out_valid<=0, go IDLE.
//   Latency: accept edge at cycle 0 -> out_valid high from cycle NR+1 (15 for NR=14).
//   Throughput: one block per NR+2 cycles minimum (out_ready tied high).
//   in_valid while not IDLE is ignored (in_ready=0); in_data sampled only on accept edge.
//   out_ready while not DONE has no effect. out_data keeps last ciphertext after handoff.
//   Back-to-back: in_ready rises the cycle after the DONE handshake. No same-cycle bypass.
//   Reset mid-ROUND or mid-DONE: block discarded, no out_valid pulse, engine back in IDLE.
//   rk_idx is a registered-state decode (no in_valid/in_data dependency); rk must settle
//     within the same cycle.
// TESTING
//   1 FIPS-197 C.3: key 000102..1f, pt 00112233445566778899aabbccddeeff
//     -> out_data 8ea2b7ca516745bfeafc49904b496089, out_valid exactly 15 cycles after accept.
//   2 All-zero key and pt -> out_data dc95c078a2408989ad48a21492842087.
//   3 rk_idx trace: 0 on accept cycle, then 1,2,..,14 on successive ROUND cycles, 0 in DONE.
//   4 out_ready low 5 cycles in DONE -> out_valid and out_data held. in_valid pulses
//     meanwhile are ignored (in_ready=0). Next block is accepted after release.
//   5 rst_n low during ROUND (ctr=7) -> outputs at reset values asynchronously. No out_valid.
//     A fresh C.3 block afterwards yields the correct ciphertext.
//   6 Two blocks back-to-back with out_ready=1 -> second accept exactly 16 cycles after the
//     first. Both ciphertexts match the reference model.

Source files
------------

// File: rtl/aes_enc_round_engine.sv
// Iterative AES encryption core: one SubBytes/ShiftRows/MixColumns/AddRoundKey round per clock.
// Round keys are fetched combinationally from an external key schedule via rk_idx/rk.
module aes_enc_round_engine #(
  parameter int NR = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TAB[8*(255-int'(x)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte 4*c+r holds row r, column c; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(4*c)   +: 8];
      a1 = s[8*(4*c+1) +: 8];
      a2 = s[8*(4*c+2) +: 8];
      a3 = s[8*(4*c+3) +: 8];
      o[8*(4*c)   +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[8*(4*c+1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[8*(4*c+2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[8*(4*c+3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   ctr_q, ctr_d;
  logic [127:0] st_q, st_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] out_data_q, out_data_d;
  logic         busy_q, busy_d;
  logic [127:0] round_sr;
  logic [127:0] round_res;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    fsm_d       = fsm_q;
    ctr_d       = ctr_q;
    st_d        = st_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;

    round_sr  = shift_rows(sub_bytes(st_q));
    round_res = ((ctr_q == LAST_ROUND) ? round_sr : mix_columns(round_sr)) ^ rk;

    unique case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          st_d       = in_data ^ rk;
          ctr_d      = 4'd1;
          fsm_d      = ROUND;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ROUND: begin
        st_d = round_res;
        if (ctr_q == LAST_ROUND) begin
          out_data_d  = round_res;
          out_valid_d = 1'b1;
          ctr_d       = 4'd0;
          fsm_d       = DONE;
        end else begin
          ctr_d = ctr_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          fsm_d       = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      ctr_q       <= 4'd0;
      st_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      ctr_q       <= ctr_d;
      st_q        <= st_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign rk_idx    = (fsm_q == ROUND) ? ctr_q : 4'd0;

endmodule

// File: tb/tb_aes_enc_round_engine.sv
// Bench for aes_enc_round_engine: acts as the AES-256 key schedule and compares ciphertexts
// against a byte-array AES model whose S-box is derived from GF(2^8) inversion.
module tb_aes_enc_round_engine;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb[256];
  logic [127:0] rkeys[15];

  typedef struct {
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[8];

  aes_enc_round_engine #(.NR(14)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk        (rk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign rk = (rk_idx <= 4'd14) ? rkeys[rk_idx] : '0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b};
    return t[15-n -: 8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] xb;
    for (int x = 0; x < 256; x++) begin
      xb  = 8'(x);
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gf_mul(inv, xb);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] fips128(input logic [127:0] v);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = v[127-8*i -: 8];
    return o;
  endfunction

  task automatic expand_key(input logic [255:0] key);
    logic [7:0] ek[240];
    logic [7:0] tmp[4];
    logic [7:0] rc;
    logic [7:0] t0;
    for (int i = 0; i < 32; i++) ek[i] = key[255-8*i -: 8];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = ek[4*(i-1)+j];
      if (i % 8 == 0) begin
        t0     = tmp[0];
        tmp[0] = sb[tmp[1]] ^ rc;
        tmp[1] = sb[tmp[2]];
        tmp[2] = sb[tmp[3]];
        tmp[3] = sb[t0];
        rc     = gf_mul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        for (int j = 0; j < 4; j++) tmp[j] = sb[tmp[j]];
      end
      for (int j = 0; j < 4; j++) ek[4*i+j] = ek[4*(i-8)+j] ^ tmp[j];
    end
    for (int n = 0; n < 15; n++)
      for (int b = 0; b < 16; b++) rkeys[n][8*b +: 8] = ek[16*n+b];
  endtask

  function automatic logic [7:0] mcoef(input int d);
    case (d)
      0:       return 8'h02;
      1:       return 8'h03;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [127:0] aes_model(input logic [127:0] pt);
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [7:0]   acc;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ rkeys[0][8*i +: 8];
    for (int rnd = 1; rnd <= 14; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) begin
          if (rnd < 14) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc ^= gf_mul(mcoef((k - r + 4) % 4), t[4*c+k]);
            s[4*c+r] = acc;
          end else begin
            s[4*c+r] = t[4*c+r];
          end
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= rkeys[rnd][8*i +: 8];
    end
    for (int i = 0; i < 16; i++) o[8*i +: 8] = s[i];
    return o;
  endfunction

  // Called at a negedge; returns at the negedge of the first out_valid cycle.
  task automatic send_block(input logic [127:0] pt, input logic [127:0] exp, input string nm);
    int cyc;
    bit trace_ok;
    cyc = 0;
    while (!in_ready && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, "_ready"}, 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    in_data  = pt;
    trace_ok = (rk_idx == 4'd0);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    cyc = 1;
    while (cyc < 40) begin
      if (out_valid) break;
      if (rk_idx != 4'(cyc) || !busy) trace_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({nm, "_latency"}, 128'(cyc), 128'd15);
    check({nm, "_data"}, out_data, exp);
    check({nm, "_rk_trace"}, 128'(trace_ok && rk_idx == 4'd0 && busy), 128'd1);
  endtask

  task automatic release_out(input logic [127:0] exp, input string nm);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({nm, "_handoff"}, {out_data, out_valid, in_ready, busy}, {exp, 1'b0, 1'b1, 1'b0});
  endtask

  logic [127:0] c3_pt;
  logic [127:0] c3_ct;
  logic [255:0] c3_key;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           acc_cyc;
    int           nout;
    int           cyc;
    bit           hold_ok;
    bit           quiet;
    logic [127:0] outs[2];
    logic [127:0] pt_b;
    logic [127:0] exp_b;

    build_sbox();
    c3_key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    c3_pt  = fips128(128'h00112233445566778899aabbccddeeff);
    c3_ct  = fips128(128'h8ea2b7ca516745bfeafc49904b496089);

    vecs[0].key = c3_key;
    vecs[0].pt  = c3_pt;
    vecs[0].exp = c3_ct;
    vecs[1].key = '0;
    vecs[1].pt  = '0;
    vecs[1].exp = fips128(128'hdc95c078a2408989ad48a21492842087);
    for (int i = 2; i < 8; i++) begin
      vecs[i].key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      vecs[i].pt  = {$urandom, $urandom, $urandom, $urandom};
      expand_key(vecs[i].key);
      vecs[i].exp = aes_model(vecs[i].pt);
    end
    expand_key(c3_key);

    repeat (2) @(negedge clk);
    check("reset_outputs", {out_data, out_valid, in_ready, busy, rk_idx},
          {128'd0, 1'b0, 1'b1, 1'b0, 4'd0});
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      expand_key(vecs[i].key);
      send_block(vecs[i].pt, vecs[i].exp, $sformatf("vec%0d", i));
      if (i == 3) begin
        hold_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
          in_valid = (k % 2 == 0);
          in_data  = {$urandom, $urandom, $urandom, $urandom};
          @(negedge clk);
          if (!out_valid || out_data !== vecs[i].exp || in_ready || !busy) hold_ok = 1'b0;
        end
        in_valid = 1'b0;
        check("done_hold", 128'(hold_ok), 128'd1);
      end
      release_out(vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Reset in the middle of ROUND, then a fresh block must still encrypt correctly.
    expand_key(c3_key);
    in_valid = 1'b1;
    in_data  = c3_pt;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_round_ctr", 128'(rk_idx), 128'd7);
    rst_n = 1'b0;
    #1;
    check("async_reset", {out_data, out_valid, in_ready, busy, rk_idx},
          {128'd0, 1'b0, 1'b1, 1'b0, 4'd0});
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid || busy) quiet = 1'b0;
    end
    check("no_valid_after_reset", 128'(quiet), 128'd1);
    send_block(c3_pt, c3_ct, "c3_after_reset");
    release_out(c3_ct, "c3_after_reset");

    // Back-to-back throughput with out_ready held high.
    expand_key(vecs[2].key);
    pt_b  = {$urandom, $urandom, $urandom, $urandom};
    exp_b = aes_model(pt_b);
    outs[0] = '0;
    outs[1] = '0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = vecs[2].pt;
    @(negedge clk);
    in_data = pt_b;
    acc_cyc = -1;
    nout    = 0;
    cyc     = 1;
    while (cyc < 80 && nout < 2) begin
      if (out_valid) begin
        outs[nout] = out_data;
        nout++;
      end
      if (in_valid && in_ready && acc_cyc < 0) acc_cyc = cyc;
      @(negedge clk);
      if (acc_cyc >= 0) in_valid = 1'b0;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_accept_gap", 128'(acc_cyc), 128'd16);
    check("b2b_out_count", 128'(nout), 128'd2);
    check("b2b_first", outs[0], vecs[2].exp);
    check("b2b_second", outs[1], exp_b);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
